// File: rtl/dmem_arbiter_if.sv
// Requester, response and memory-port bundle for dmem_arbiter.
// slave: arbiter side. master: side that drives the requests and the memory read data.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Port 0: pipeline memory stage
    logic              i_p0_req;
    logic              i_p0_we;
    logic [ADDR_W-1:0] i_p0_addr;
    logic [DATA_W-1:0] i_p0_wdata;
    logic [2:0]        i_p0_mode;
    logic              o_p0_gnt;
    logic              o_p0_stall;
    logic              o_p0_rvalid;
    logic [DATA_W-1:0] o_p0_rdata;

    // Port 1: loader/debug master
    logic              i_p1_req;
    logic              i_p1_we;
    logic [ADDR_W-1:0] i_p1_addr;
    logic [DATA_W-1:0] i_p1_wdata;
    logic [2:0]        i_p1_mode;
    logic              i_p1_lock;
    logic              o_p1_gnt;
    logic              o_p1_rvalid;
    logic [DATA_W-1:0] o_p1_rdata;

    // Shared data memory port
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [2:0]        o_mem_mode;
    logic [DATA_W-1:0] i_mem_rdata;

    modport slave (
        input  i_p0_req, i_p0_we, i_p0_addr, i_p0_wdata, i_p0_mode,
        input  i_p1_req, i_p1_we, i_p1_addr, i_p1_wdata, i_p1_mode, i_p1_lock,
        input  i_mem_rdata,
        output o_p0_gnt, o_p0_stall, o_p0_rvalid, o_p0_rdata,
        output o_p1_gnt, o_p1_rvalid, o_p1_rdata,
        output o_mem_we, o_mem_addr, o_mem_wdata, o_mem_mode
    );

    modport master (
        output i_p0_req, i_p0_we, i_p0_addr, i_p0_wdata, i_p0_mode,
        output i_p1_req, i_p1_we, i_p1_addr, i_p1_wdata, i_p1_mode, i_p1_lock,
        output i_mem_rdata,
        input  o_p0_gnt, o_p0_stall, o_p0_rvalid, o_p0_rdata,
        input  o_p1_gnt, o_p1_rvalid, o_p1_rdata,
        input  o_mem_we, o_mem_addr, o_mem_wdata, o_mem_mode
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single data memory port.
// Round-robin between the memory stage (port 0) and the loader (port 1), with a bounded
// exclusive burst lock for port 1. Load data is registered one cycle after grant.
// Optional perf counters (o_conflict_cnt, o_forced_rel_cnt) exist only when
// DMEM_ARB_PERF_EN is defined.
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]    o_conflict_cnt,
    output logic [15:0]    o_forced_rel_cnt
`endif
);

    localparam logic [7:0] MaxLock = 8'(MAX_LOCK);

    typedef enum logic [0:0] {StArb, StLock} state_e;

    state_e            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic [7:0]        lock_cnt_q, lock_cnt_d;
    logic              p0_rvalid_q, p0_rvalid_d;
    logic              p1_rvalid_q, p1_rvalid_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              gnt0, gnt1, forced_rel;

    // Grant decision and arbitration/lock next state; no grant while in reset
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        lock_cnt_d = lock_cnt_q;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        forced_rel = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                StArb: begin
                    if (bus.i_p0_req && (!bus.i_p1_req || last_gnt_q)) begin
                        gnt0 = 1'b1;
                    end else if (bus.i_p1_req) begin
                        gnt1 = 1'b1;
                    end
                    if (gnt0) begin
                        last_gnt_d = 1'b0;
                    end
                    if (gnt1) begin
                        last_gnt_d = 1'b1;
                        if (bus.i_p1_lock) begin
                            lock_cnt_d = 8'd1;
                            // A one-cycle budget is already spent by this grant
                            if (MaxLock == 8'd1) begin
                                forced_rel = 1'b1;
                            end else begin
                                state_d = StLock;
                            end
                        end
                    end
                end
                StLock: begin
                    gnt1       = bus.i_p1_req;
                    lock_cnt_d = lock_cnt_q + 8'd1;
                    if (gnt1) begin
                        last_gnt_d = 1'b1;
                    end
                    if (!bus.i_p1_lock) begin
                        state_d = StArb;
                    end else if (lock_cnt_d == MaxLock) begin
                        // Hand the next conflict to port 0
                        state_d    = StArb;
                        last_gnt_d = 1'b1;
                        forced_rel = 1'b1;
                    end
                end
                default: state_d = StArb;
            endcase
        end
    end

    // Memory port mux from the granted requester
    always_comb begin
        bus.o_mem_we    = 1'b0;
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;
        bus.o_mem_mode  = '0;
        if (gnt0) begin
            bus.o_mem_we    = bus.i_p0_we;
            bus.o_mem_addr  = bus.i_p0_addr;
            bus.o_mem_wdata = bus.i_p0_wdata;
            bus.o_mem_mode  = bus.i_p0_mode;
        end else if (gnt1) begin
            bus.o_mem_we    = bus.i_p1_we;
            bus.o_mem_addr  = bus.i_p1_addr;
            bus.o_mem_wdata = bus.i_p1_wdata;
            bus.o_mem_mode  = bus.i_p1_mode;
        end
    end

    // Load responses: capture read data for granted loads, otherwise hold
    always_comb begin
        p0_rvalid_d = gnt0 && !bus.i_p0_we;
        p1_rvalid_d = gnt1 && !bus.i_p1_we;
        p0_rdata_d  = p0_rvalid_d ? bus.i_mem_rdata : p0_rdata_q;
        p1_rdata_d  = p1_rvalid_d ? bus.i_mem_rdata : p1_rdata_q;
    end

    // State and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StArb;
            last_gnt_q  <= 1'b1;
            lock_cnt_q  <= 8'd0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            lock_cnt_q  <= lock_cnt_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    assign bus.o_p0_gnt    = gnt0;
    assign bus.o_p0_stall  = bus.i_p0_req & ~gnt0;
    assign bus.o_p0_rvalid = p0_rvalid_q;
    assign bus.o_p0_rdata  = p0_rdata_q;
    assign bus.o_p1_gnt    = gnt1;
    assign bus.o_p1_rvalid = p1_rvalid_q;
    assign bus.o_p1_rdata  = p1_rdata_q;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] conflict_cnt_q, conflict_cnt_d;
    logic [15:0] forced_cnt_q, forced_cnt_d;

    // Saturating counters; both requesting always means one is denied
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        forced_cnt_d   = forced_cnt_q;
        if (rst_n && bus.i_p0_req && bus.i_p1_req && (conflict_cnt_q != '1)) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
        if (forced_rel && (forced_cnt_q != '1)) begin
            forced_cnt_d = forced_cnt_q + 16'd1;
        end
    end

    // Perf counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_q <= '0;
            forced_cnt_q   <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
            forced_cnt_q   <= forced_cnt_d;
        end
    end

    assign o_conflict_cnt   = conflict_cnt_q;
    assign o_forced_rel_cnt = forced_cnt_q;
`endif

endmodule
